// File: rtl/irq_ctrl_din_pkg.sv
// Shared types and constants for the irq_ctrl_din interrupt controller.
package irq_ctrl_din_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

  localparam int MAX_IRQ          = 32;
  localparam int IRQ_TIMER_IDX    = 0;
  localparam int IRQ_EBREAK_IDX   = 1;
  localparam int IRQ_BUSERROR_IDX = 2;

endpackage

// File: rtl/irq_ctrl_din_prio_enc.sv
// Fixed-priority encoder: the lowest set index of eff_i wins.
module irq_prio_enc
  import irq_ctrl_din_pkg::*;
#(
  parameter int N    = MAX_IRQ,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    eff_i,
  output logic            valid_o,
  output logic [ID_W-1:0] id_o
);

  // Scan from the top down so the last hit (lowest index) is what remains.
  always_comb begin
    valid_o = 1'b0;
    id_o    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (eff_i[i]) begin
        valid_o = 1'b1;
        id_o    = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl_din.sv
// Parametrised interrupt controller with req/ack/eoi handshake and lost-edge trap.
// Optional internal down-counter timer on channel IRQ_TIMER: define IRQ_CTRL_DIN_TIMER_EN.
module irq_ctrl_din
  import irq_ctrl_din_pkg::*;
#(
  parameter int                 NUM_IRQ     = 32,
  parameter logic [MAX_IRQ-1:0] MASKED_IRQ  = 32'h0000_0000,
  parameter logic [MAX_IRQ-1:0] LATCHED_IRQ = 32'hffff_ffff,
  parameter int                 IRQ_TIMER   = IRQ_TIMER_IDX,
  parameter int                 TIMER_W     = 16,
  parameter int                 ID_W        = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
`ifdef IRQ_CTRL_DIN_TIMER_EN
  input  logic               timer_load,
  input  logic [TIMER_W-1:0] timer_wdata,
`endif
  input  logic               mask_wr,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  output logic [NUM_IRQ-1:0] irq_mask,
  output logic [NUM_IRQ-1:0] irq_pending,
  output logic               irq_req,
  output logic [ID_W-1:0]    irq_id,
  input  logic               irq_ack,
  input  logic               irq_eoi,
  output logic               trap,
  input  logic               trap_clr
);

  localparam logic [NUM_IRQ-1:0] STATIC_MASK = MASKED_IRQ[NUM_IRQ-1:0];
`ifdef IRQ_CTRL_DIN_TIMER_EN
  localparam logic [NUM_IRQ-1:0] TIMER_BIT = {{(NUM_IRQ-1){1'b0}}, 1'b1} << IRQ_TIMER;
  localparam logic [NUM_IRQ-1:0] LATCH_SEL = LATCHED_IRQ[NUM_IRQ-1:0] | TIMER_BIT;
`else
  localparam logic [NUM_IRQ-1:0] LATCH_SEL = LATCHED_IRQ[NUM_IRQ-1:0];
`endif

  irq_state_e         state_q;
  logic               req_q;
  logic [ID_W-1:0]    id_q;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] prev_q;
  logic               trap_q, trap_d;
  logic [NUM_IRQ-1:0] rise_vec;
  logic [NUM_IRQ-1:0] eff;
  logic               enc_valid;
  logic [ID_W-1:0]    enc_id;
  logic               ack_fire;

`ifdef IRQ_CTRL_DIN_TIMER_EN
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               tmr_fire;

  // Only a decrement from 1 fires; a load (including a load of 0) never does.
  always_comb begin
    tmr_fire = !timer_load && (timer_q == TIMER_W'(1));
    if (timer_load)
      timer_d = timer_wdata;
    else if (timer_q != '0)
      timer_d = timer_q - TIMER_W'(1);
    else
      timer_d = timer_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) timer_q <= '0;
    else       timer_q <= timer_d;
  end
`endif

  always_comb begin
    rise_vec = irq_in & ~prev_q;
`ifdef IRQ_CTRL_DIN_TIMER_EN
    rise_vec[IRQ_TIMER] = tmr_fire;
`endif
  end

  assign ack_fire = (state_q == REQ) && irq_ack;

  // A new edge beats a same-cycle ack clear; level channels just follow the line.
  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (LATCH_SEL[i]) begin
        if (ack_fire && (id_q == ID_W'(i))) pending_d[i] = 1'b0;
        if (rise_vec[i])                    pending_d[i] = 1'b1;
      end else begin
        pending_d[i] = irq_in[i];
      end
    end
  end

  always_comb begin
    trap_d = trap_q & ~trap_clr;
    if (|(rise_vec & pending_q & LATCH_SEL)) trap_d = 1'b1;
    mask_d = mask_wr ? mask_wdata : mask_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q    <= '0;
      pending_q <= '0;
      prev_q    <= '0;
      trap_q    <= 1'b0;
    end else begin
      mask_q    <= mask_d;
      pending_q <= pending_d;
      prev_q    <= irq_in;
      trap_q    <= trap_d;
    end
  end

  assign eff = pending_q & ~mask_q & ~STATIC_MASK;

  irq_prio_enc #(
    .N    (NUM_IRQ),
    .ID_W (ID_W)
  ) u_prio_enc (
    .eff_i   (eff),
    .valid_o (enc_valid),
    .id_o    (enc_id)
  );

  // Once raised, the request and its id stay put until the core acks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      id_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enc_valid) begin
            id_q    <= enc_id;
            req_q   <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (irq_ack) begin
            req_q   <= 1'b0;
            state_q <= SERVICE;
          end
        end
        SERVICE: begin
          if (irq_eoi) state_q <= IDLE;
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign irq_mask    = mask_q;
  assign irq_pending = pending_q;
  assign irq_req     = req_q;
  assign irq_id      = id_q;
  assign trap        = trap_q;

endmodule
